// File: rtl/apb_cmd_master_if.sv
// Command/response and APB requester signal bundle for apb_cmd_master.
// master modport is the block's own view; slave is the environment's view.
interface apb_cmd_master_if #(
  parameter int unsigned ADDR_WD = 12
) ();
  logic               cmd_valid;
  logic               cmd_ready;
  logic [ADDR_WD-1:0] cmd_addr;
  logic               cmd_write;
  logic [31:0]        cmd_wdata;
  logic               rsp_valid;
  logic [31:0]        rsp_rdata;
  logic               rsp_err;
  logic               psel;
  logic               penable;
  logic               pwrite;
  logic [ADDR_WD-1:0] paddr;
  logic [31:0]        pwdata;
  logic [31:0]        prdata;
  logic               pready;
  logic               pslverr;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_cmd_master.sv
// Single-outstanding command to APB requester bridge (IDLE -> SETUP -> ACCESS).
// Define APB_CMD_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC cycles without pready.
module apb_cmd_master #(
  parameter int unsigned ADDR_WD     = 12,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input logic              pclk,
  input logic              preset_n,
  apb_cmd_master_if.master bus
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be within 2..65535");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e             state_q, state_d;
  logic [ADDR_WD-1:0] paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               timeout;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // cnt_q equals the number of wait cycles already spent in the current ACCESS phase
  assign timeout = (cnt_q == 16'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StSetup) begin
      cnt_d = '0;
    end else if (state_q == StAccess && !bus.pready) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          state_d  = StSetup;
          paddr_d  = bus.cmd_addr;
          pwrite_d = bus.cmd_write;
          pwdata_d = bus.cmd_write ? bus.cmd_wdata : 32'd0;
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        // A completing pready wins over a timeout in the same cycle
        if (bus.pready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.pslverr;
          rsp_rdata_d = pwrite_q ? 32'd0 : bus.prdata;
        end else if (timeout) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= StIdle;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.psel      = (state_q != StIdle);
  assign bus.penable   = (state_q == StAccess);
  assign bus.paddr     = paddr_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: transaction-level model checked every cycle plus
// literal expectations on latency, wait-state, busy, reset and timeout scenarios.
module tb_apb_cmd_master;
  localparam int unsigned AW  = 12;
  localparam int unsigned TMO = 8;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic pclk;
  logic preset_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  apb_cmd_master_if #(.ADDR_WD(AW)) bus ();

  apb_cmd_master #(.ADDR_WD(AW), .TIMEOUT_CYC(TMO)) dut (
    .pclk    (pclk),
    .preset_n(preset_n),
    .bus     (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Transaction-level model: one command in flight, counted by phase and wait cycles.
  bit            m_busy = 0;
  bit            m_acc  = 0;
  int            m_wait = 0;
  bit            m_rsp  = 0;
  bit            m_err  = 0;
  bit            m_wr   = 0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0]   m_wd   = '0;
  logic [31:0]   m_rd   = '0;

  always @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      m_busy <= 0; m_acc <= 0; m_wait <= 0; m_rsp <= 0; m_err <= 0;
      m_wr <= 0; m_addr <= '0; m_wd <= '0; m_rd <= '0;
    end else begin
      m_rsp <= 0;
      if (!m_busy) begin
        if (bus.cmd_valid) begin
          m_busy <= 1; m_acc <= 0; m_wait <= 0;
          m_addr <= bus.cmd_addr; m_wr <= bus.cmd_write;
          m_wd   <= bus.cmd_write ? bus.cmd_wdata : 32'd0;
        end
      end else if (!m_acc) begin
        m_acc <= 1;
      end else if (bus.pready) begin
        m_busy <= 0; m_acc <= 0; m_rsp <= 1;
        m_err  <= bus.pslverr; m_rd <= m_wr ? 32'd0 : bus.prdata;
      end else if (TmoEn && (m_wait + 1 == int'(TMO))) begin
        m_busy <= 0; m_acc <= 0; m_rsp <= 1; m_err <= 1; m_rd <= 32'd0;
      end else begin
        m_wait <= m_wait + 1;
      end
    end
  end

  always @(negedge pclk) begin
    chk("cmd_ready", 32'(bus.cmd_ready), 32'(!m_busy));
    chk("psel",      32'(bus.psel),      32'(m_busy));
    chk("penable",   32'(bus.penable),   32'(m_busy && m_acc));
    chk("paddr",     32'(bus.paddr),     32'(m_addr));
    chk("pwrite",    32'(bus.pwrite),    32'(m_wr));
    chk("pwdata",    bus.pwdata,         m_wd);
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp));
    if (m_rsp) begin
      chk("rsp_err",   32'(bus.rsp_err), 32'(m_err));
      chk("rsp_rdata", bus.rsp_rdata,    m_rd);
    end
  end

  // Issue one command; pready stays low for 'waits' ACCESS cycles, then completes with err/rd.
  task automatic run_cmd(input logic [AW-1:0] addr, input bit wr, input logic [31:0] wd,
                         input int waits, input bit err, input logic [31:0] rd,
                         output int lat, output int acc, output bit got_err,
                         output logic [31:0] got_rd, output bit ready_at_rsp);
    bit got;
    int moved;
    @(posedge pclk); #1;
    bus.cmd_valid = 1; bus.cmd_addr = addr; bus.cmd_write = wr; bus.cmd_wdata = wd;
    bus.pready = (waits == 0); bus.pslverr = (waits == 0) ? err : 1'b1;
    bus.prdata = (waits == 0) ? rd : 32'hDEAD_BEEF;
    @(posedge pclk); #1;
    bus.cmd_valid = 0; bus.cmd_addr = ~addr; bus.cmd_wdata = 32'hFFFF_0000;
    lat = 0; acc = 0; got = 0; moved = 0; got_err = 0; got_rd = '0; ready_at_rsp = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge pclk);
      lat++;
      if (bus.penable) begin
        acc++;
        if (bus.paddr !== addr) moved++;
        if (acc > waits) begin
          bus.pready = 1; bus.pslverr = err; bus.prdata = rd;
        end else begin
          bus.pready = 0; bus.pslverr = 1; bus.prdata = 32'hDEAD_BEEF;
        end
      end
      if (bus.rsp_valid) begin
        got = 1; got_err = bus.rsp_err; got_rd = bus.rsp_rdata; ready_at_rsp = bus.cmd_ready;
      end
    end
    chk("rsp_seen", 32'(got), 32'd1);
    chk("paddr_stable_moves", 32'(moved), 32'd0);
    bus.pready = 0; bus.pslverr = 0; bus.prdata = 32'h0;
    @(negedge pclk);
    chk("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
  endtask

  int          lat, acc, n_acc, n_rsp;
  int          acc_t[2];
  bit          e, rdy;
  logic [31:0] rd;

  initial begin
    preset_n = 0;
    bus.cmd_valid = 0; bus.cmd_addr = '0; bus.cmd_write = 0; bus.cmd_wdata = '0;
    bus.prdata = '0; bus.pready = 0; bus.pslverr = 0;
    repeat (2) @(negedge pclk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_psel",      32'(bus.psel),      32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_pwdata",    bus.pwdata,         32'd0);
    @(posedge pclk); #1 preset_n = 1;

    // Zero-wait write
    run_cmd(12'h010, 1, 32'hA5A5_5A5A, 0, 0, 32'h7777_7777, lat, acc, e, rd, rdy);
    chk("wr0_latency", 32'(lat), 32'd3);
    chk("wr0_access",  32'(acc), 32'd1);
    chk("wr0_err",     32'(e),   32'd0);
    chk("wr0_rdata",   rd,       32'd0);
    chk("wr0_ready",   32'(rdy), 32'd1);

    // Read with 3 wait states
    run_cmd(12'h004, 0, 32'h1111_2222, 3, 0, 32'h1234_5678, lat, acc, e, rd, rdy);
    chk("rd3_latency", 32'(lat), 32'd6);
    chk("rd3_access",  32'(acc), 32'd4);
    chk("rd3_rdata",   rd,       32'h1234_5678);
    chk("rd3_err",     32'(e),   32'd0);

    // Slave error on a read
    run_cmd(12'hFFF, 0, 32'h0, 0, 1, 32'hCAFE_F00D, lat, acc, e, rd, rdy);
    chk("err_flag",  32'(e), 32'd1);
    chk("err_rdata", rd,     32'hCAFE_F00D);

    // Write with one wait and a slave error
    run_cmd(12'h800, 1, 32'h0BAD_C0DE, 1, 1, 32'h5555_AAAA, lat, acc, e, rd, rdy);
    chk("wr1_access", 32'(acc), 32'd2);
    chk("wr1_err",    32'(e),   32'd1);
    chk("wr1_rdata",  rd,       32'd0);

    // cmd_valid held: second accept only once cmd_ready returns
    @(posedge pclk); #1;
    bus.cmd_valid = 1; bus.cmd_addr = 12'h020; bus.cmd_write = 1; bus.cmd_wdata = 32'h1;
    bus.pready = 1;
    n_acc = 0;
    for (int i = 0; i < 20 && n_acc < 2; i++) begin
      @(negedge pclk);
      if (bus.cmd_ready) begin
        acc_t[n_acc] = cyc;
        n_acc++;
      end
    end
    @(posedge pclk); #1 bus.cmd_valid = 0;
    chk("busy_accepts", 32'(n_acc), 32'd2);
    chk("busy_gap", 32'(acc_t[1] - acc_t[0]), 32'd3);
    repeat (4) @(posedge pclk);
    #1 bus.pready = 0;

    // Reset during an ACCESS wait state
    @(posedge pclk); #1;
    bus.cmd_valid = 1; bus.cmd_addr = 12'h044; bus.cmd_write = 0;
    @(posedge pclk); #1 bus.cmd_valid = 0;
    repeat (2) @(posedge pclk);
    #1;
    chk("mid_penable", 32'(bus.penable), 32'd1);
    preset_n = 0;
    #1;
    chk("mid_rst_psel",    32'(bus.psel),    32'd0);
    chk("mid_rst_penable", 32'(bus.penable), 32'd0);
    repeat (2) @(posedge pclk);
    #1 preset_n = 1;
    bus.pready = 1; bus.prdata = 32'h9999_9999;
    n_rsp = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      if (bus.rsp_valid) n_rsp++;
    end
    chk("mid_rst_no_rsp", 32'(n_rsp), 32'd0);
    chk("mid_rst_ready",  32'(bus.cmd_ready), 32'd1);
    bus.pready = 0;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    run_cmd(12'h0C0, 0, 32'h0, 1000, 0, 32'h4444_4444, lat, acc, e, rd, rdy);
    chk("tmo_access", 32'(acc), 32'(TMO));
    chk("tmo_err",    32'(e),   32'd1);
    chk("tmo_rdata",  rd,       32'd0);
    chk("tmo_ready",  32'(rdy), 32'd1);
`endif

    repeat (2) @(negedge pclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 The block SHALL have parameter ADDR_WD, default 12, which is the APB address width.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 256, which is the maximum number of ACCESS cycles waited before a timeout abort; it SHALL be in the range 2..65535.
REQ-003 Port pclk SHALL be an input of width 1: the single clock; all logic is rising-edge.
REQ-004 Port preset_n SHALL be an input of width 1: the asynchronous, active-low reset.
REQ-005 Port cmd_valid SHALL be an input of width 1: a command request.
REQ-006 Port cmd_ready SHALL be an output of width 1: the block can accept a command.
REQ-007 Port cmd_addr SHALL be an input of width ADDR_WD: the command address.
REQ-008 Port cmd_write SHALL be an input of width 1: 1 = write, 0 = read.
REQ-009 Port cmd_wdata SHALL be an input of width 32: the write data.
REQ-010 Port rsp_valid SHALL be an output of width 1: a one-cycle response pulse.
REQ-011 Port rsp_rdata SHALL be an output of width 32: the read data, valid with rsp_valid.
REQ-012 Port rsp_err SHALL be an output of width 1: the error flag, valid with rsp_valid.
REQ-013 The block SHALL have the APB requester outputs psel, penable, pwrite (width 1 each), paddr (width ADDR_WD) and pwdata (width 32).
REQ-014 The block SHALL have the APB requester inputs prdata (width 32), pready (width 1) and pslverr (width 1).

Function
REQ-015 The state machine SHALL have three states: IDLE, SETUP and ACCESS.
REQ-016 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid and cmd_ready are both 1 on a clock edge.
REQ-017 On accept, the block SHALL register cmd_addr, cmd_write and cmd_wdata, then go to SETUP.
REQ-018 In SETUP the outputs SHALL be psel=1 and penable=0; the state SHALL go to ACCESS unconditionally after one cycle.
REQ-019 In ACCESS the outputs SHALL be psel=1 and penable=1; the block SHALL stay in ACCESS while pready=0.
REQ-020 When in ACCESS with pready=1, the block SHALL assert rsp_valid for the next single cycle and return to IDLE.
REQ-021 On that completion, rsp_err SHALL be set from pslverr.
REQ-022 On that completion, rsp_rdata SHALL be set from prdata for a read and to 0 for a write.
REQ-023 paddr, pwrite and pwdata SHALL stay stable from SETUP through the last ACCESS cycle.
REQ-024 pwdata SHALL be 0 for reads.
REQ-025 Minimum latency SHALL be: accept at edge T, SETUP in cycle T+1, ACCESS in cycle T+2; with pready=1 in T+2, rsp_valid is high in T+3 and cmd_ready is high in T+3.
REQ-026 Transfers SHALL be back-to-back only via IDLE: there is no SETUP bypass, and there is a minimum of 3 cycles between accepts.
REQ-027 rsp_valid SHALL have no backpressure; the consumer samples it on the pulse.
REQ-028 cmd_valid in SETUP or ACCESS SHALL be ignored (cmd_ready=0); commands SHALL not be queued.
REQ-029 In IDLE the outputs SHALL be psel=0 and penable=0; paddr, pwrite and pwdata SHALL hold their last values.
REQ-030 pslverr and prdata SHALL be ignored when not in ACCESS with pready=1.

Reset
REQ-031 When preset_n=0, the state SHALL go to IDLE asynchronously.
REQ-032 During reset, psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err, rsp_rdata and the timeout counter SHALL all be 0.
REQ-033 cmd_ready SHALL be 1 during reset and after reset release.
REQ-034 A reset mid-transfer SHALL abort the transfer with no rsp_valid; psel and penable SHALL drop immediately.

Configuration
REQ-035 The macro APB_CMD_MASTER_TIMEOUT_EN SHALL compile the timeout feature in or out.
REQ-036 When APB_CMD_MASTER_TIMEOUT_EN is defined, a 16-bit counter SHALL clear on entering ACCESS and increment on each ACCESS cycle with pready=0.
REQ-037 With the timeout compiled in, when the count reaches TIMEOUT_CYC-1 and pready is still 0, the block SHALL end the transfer: it goes to IDLE and pulses rsp_valid with rsp_err=1 and rsp_rdata=0.
REQ-038 With the timeout compiled in, if pready=1 in that same cycle, normal completion SHALL take priority.
REQ-039 When APB_CMD_MASTER_TIMEOUT_EN is not defined, the counter SHALL not exist and ACCESS SHALL wait for pready indefinitely.

Verification
REQ-040 The bench SHALL cover a zero-wait write: cmd addr=0x010, wdata=0xA5A5_5A5A, pready tied to 1 -> SETUP then ACCESS in 2 cycles, then rsp_valid=1 with rsp_err=0 and rsp_rdata=0.
REQ-041 The bench SHALL cover a read with 3 wait states: addr=0x004, pready low for 3 ACCESS cycles, prdata=0x1234_5678 -> ACCESS lasts 4 cycles, paddr is stable throughout, and rsp_rdata=0x1234_5678.
REQ-042 The bench SHALL cover a slave error: a read with pslverr=1 and pready=1 -> rsp_err=1 and rsp_valid lasts exactly 1 cycle.
REQ-043 The bench SHALL cover a busy drop: cmd_valid held through a transfer -> a second accept occurs only when cmd_ready=1 again (3 cycles after the first accept at zero wait).
REQ-044 The bench SHALL cover reset mid-ACCESS: preset_n=0 during a wait state -> psel=0 at once, there is no rsp_valid, and cmd_ready=1 after release.
REQ-045 The bench SHALL cover timeout (with APB_CMD_MASTER_TIMEOUT_EN, TIMEOUT_CYC=8): pready held 0 -> after 8 ACCESS cycles the block pulses rsp_valid with rsp_err=1 and returns to IDLE.
